// File: rtl/dir_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dir_input_ctrl
// Brief    : Debounced direction buttons -> committed snake heading, one turn per move.
// Revision : 1.0
// ============================================================================
module dir_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_W           = 14
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] btn_raw,
    input  logic       move_tick,
    output logic [3:0] direction,
    output logic [1:0] heading,
    output logic       dir_change
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_stable;
    logic [3:0] r_stable_q;
    logic [3:0] w_press_vec;

    logic       w_press_any;
    logic [1:0] w_press_code;
    logic       w_press_valid;
    logic [1:0] w_next_heading;

    logic [1:0] r_heading;
    logic [3:0] r_direction;
    logic       r_dir_change;
    logic [1:0] r_pending;
    logic       r_pending_valid;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_sync1    <= 4'b0000;
            r_sync2    <= 4'b0000;
            r_stable_q <= 4'b0000;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_stable_q <= w_stable;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_deb
            logic [CNT_W-1:0] r_cnt;
            logic             r_stable;

            always_ff @(posedge clk or posedge clear) begin
                if (clear) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync2[i] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_stable <= ~r_stable;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end

            assign w_stable[i] = r_stable;
        end
    endgenerate

    // Rising edge of the debounced level only; releases are ignored.
    assign w_press_vec = w_stable & ~r_stable_q;

    always_comb begin
        w_press_any  = 1'b1;
        w_press_code = 2'b11;
        if (w_press_vec[3])      w_press_code = 2'b11;
        else if (w_press_vec[0]) w_press_code = 2'b00;
        else if (w_press_vec[1]) w_press_code = 2'b01;
        else if (w_press_vec[2]) w_press_code = 2'b10;
        else                     w_press_any  = 1'b0;
    end

    // With this encoding the reverse heading is the bitwise complement.
    assign w_press_valid = w_press_any
                         && (w_press_code != r_heading)
                         && (w_press_code != ~r_heading);

    always_comb begin
        w_next_heading = r_heading;
        if (w_press_valid)        w_next_heading = w_press_code;
        else if (r_pending_valid) w_next_heading = r_pending;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_heading       <= 2'b11;
            r_direction     <= 4'b1000;
            r_dir_change    <= 1'b0;
            r_pending       <= 2'b11;
            r_pending_valid <= 1'b0;
        end else if (move_tick) begin
            r_heading       <= w_next_heading;
            r_direction     <= 4'b0001 << w_next_heading;
            r_dir_change    <= (w_next_heading != r_heading);
            r_pending_valid <= 1'b0;
        end else begin
            r_dir_change <= 1'b0;
            if (w_press_valid) begin
                r_pending       <= w_press_code;
                r_pending_valid <= 1'b1;
            end
        end
    end

    assign heading    = r_heading;
    assign direction  = r_direction;
    assign dir_change = r_dir_change;

endmodule
`default_nettype wire

// File: tb/tb_dir_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dir_input_ctrl
// Brief    : Scoreboard bench for dir_input_ctrl with DEBOUNCE_CYCLES=4.
// Revision : 1.0
// ============================================================================
module tb_dir_input_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] btn_raw;
    logic       move_tick;
    logic [3:0] direction;
    logic [1:0] heading;
    logic       dir_change;

    dir_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .btn_raw    (btn_raw),
        .move_tick  (move_tick),
        .direction  (direction),
        .heading    (heading),
        .dir_change (dir_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] hd;
        logic       dc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [1:0] m_h;
    logic [1:0] m_p;
    logic       m_pv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] prio(input logic [3:0] m);
        if (m[3]) return 2'b11;
        if (m[0]) return 2'b00;
        if (m[1]) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] c);
        case (c)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic is_valid(input logic [1:0] c);
        return (c != m_h) && (c != ~m_h);
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_press(input logic [3:0] m);
        if (is_valid(prio(m))) begin
            m_p  = prio(m);
            m_pv = 1'b1;
        end
    endtask

    task automatic do_tick(input logic has_press, input logic [3:0] m);
        exp_t       e;
        logic [1:0] nh;
        nh = m_h;
        if (has_press && is_valid(prio(m))) nh = prio(m);
        else if (m_pv)                      nh = m_p;
        e.hd = nh;
        e.dc = (nh != m_h);
        sb_q.push_back(e);
        m_h  = nh;
        m_pv = 1'b0;
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("heading", {30'd0, heading}, {30'd0, e.hd});
            chk("direction", {28'd0, direction}, {28'd0, onehot(e.hd)});
            chk("dir_change", {31'd0, dir_change}, {31'd0, e.dc});
        end
        cyc();
        chk("dir_change_clr", {31'd0, dir_change}, 32'd0);
    endtask

    task automatic press(input logic [3:0] m);
        btn_raw = m;
        repeat (10) cyc();
        btn_raw = 4'b0000;
        repeat (10) cyc();
        model_press(m);
    endtask

    // Button already driven; the press event lands exactly 2 + 4 edges later.
    task automatic tick_at_arrival(input logic [3:0] m);
        repeat (6) cyc();
        do_tick(1'b1, m);
        btn_raw = 4'b0000;
        repeat (10) cyc();
    endtask

    task automatic pulse_clear();
        #1 clear = 1'b1;
        #1;
        chk("rst_async_heading", {30'd0, heading}, 32'd3);
        chk("rst_async_direction", {28'd0, direction}, 32'h8);
        chk("rst_async_dir_change", {31'd0, dir_change}, 32'd0);
        #1 clear = 1'b0;
        m_h  = 2'b11;
        m_p  = 2'b11;
        m_pv = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        clear     = 1'b1;
        btn_raw   = 4'b0000;
        move_tick = 1'b0;
        m_h  = 2'b11;
        m_p  = 2'b11;
        m_pv = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_heading", {30'd0, heading}, 32'd3);
        chk("rst_direction", {28'd0, direction}, 32'h8);
        chk("rst_dir_change", {31'd0, dir_change}, 32'd0);
        clear = 1'b0;
        cyc();
        chk("post_rst_heading", {30'd0, heading}, 32'd3);

        // Bouncing up button settles into a single press, committed at cycle 20
        btn_raw = 4'b0100; cyc();
        btn_raw = 4'b0000; cyc();
        btn_raw = 4'b0100;
        repeat (17) cyc();
        model_press(4'b0100);
        do_tick(1'b0, 4'b0000);
        btn_raw = 4'b0000;
        repeat (10) cyc();
        do_tick(1'b0, 4'b0000);

        // Tick one edge before the press arrives: nothing commits, press goes pending
        btn_raw = 4'b1000;
        repeat (5) cyc();
        do_tick(1'b0, 4'b0000);
        model_press(4'b1000);
        btn_raw = 4'b0000;
        repeat (10) cyc();
        do_tick(1'b0, 4'b0000);

        // Reversal rejected
        press(4'b0001);
        do_tick(1'b0, 4'b0000);

        // Last press wins
        press(4'b0100);
        press(4'b0010);
        do_tick(1'b0, 4'b0000);

        // Walk to up, queue left, then right arrives with the tick
        press(4'b0001);
        do_tick(1'b0, 4'b0000);
        press(4'b0100);
        do_tick(1'b0, 4'b0000);
        press(4'b0001);
        btn_raw = 4'b1000;
        tick_at_arrival(4'b1000);
        do_tick(1'b0, 4'b0000);

        // Priority: right over left, down over up
        press(4'b0100);
        do_tick(1'b0, 4'b0000);
        press(4'b1001);
        do_tick(1'b0, 4'b0000);
        press(4'b0110);
        do_tick(1'b0, 4'b0000);

        // Heading right: up then left leaves up pending
        press(4'b1000);
        do_tick(1'b0, 4'b0000);
        press(4'b0100);
        press(4'b0001);
        do_tick(1'b0, 4'b0000);

        // Clear discards pending and mid-debounce state
        press(4'b0001);
        btn_raw = 4'b0010;
        repeat (3) cyc();
        pulse_clear();
        btn_raw = 4'b0000;
        repeat (10) cyc();
        do_tick(1'b0, 4'b0000);

        // Button held through clear release
        btn_raw = 4'b0100;
        pulse_clear();
        tick_at_arrival(4'b0100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
